// File: rtl/qdr_test_pkg.sv
// Shared types and constants for the QDR memory test sequencer.
package qdr_test_pkg;
  typedef enum logic [2:0] {
    IDLE, WAIT_CAL, RESET_GEN, RUN, CHECK, NEXT, FINISH
  } state_t;

  localparam int RST_CYCLES  = 4;
  localparam int TOTAL_ERR_W = 16;
endpackage

// File: rtl/seq_timeout_counter.sv
// RUN-phase cycle counter; tc is high once the count reaches TIMEOUT_CYCLES-1.
module seq_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (enable && !tc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == LAST);
endmodule

// File: rtl/qdr_test_sequencer.sv
// Sequences reset/start/check of attached AXI traffic generators over several
// passes and accumulates pass/fail status for a QDR memory test.
module qdr_test_sequencer
  import qdr_test_pkg::*;
#(
  parameter int NUM_GEN        = 2,
  parameter int ERR_W          = 7,
  parameter int NUM_ITER       = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_calib_complete,
  input  logic                     start,
  input  logic                     abort,
  output logic [NUM_GEN-1:0]       gen_rst_n,
  output logic [NUM_GEN-1:0]       gen_start,
  input  logic [NUM_GEN-1:0]       gen_done,
  input  logic [NUM_GEN*ERR_W-1:0] gen_err_cnt,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic                     aborted,
  output logic [NUM_GEN-1:0]       fail_mask,
  output logic [7:0]               iter_cnt,
  output logic [TOTAL_ERR_W-1:0]   total_err
);
  localparam int SEL_W = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1;
  localparam logic [2:0] RST_LAST = 3'(RST_CYCLES - 1);

  function automatic logic [TOTAL_ERR_W-1:0] sat_add(input logic [TOTAL_ERR_W-1:0] a,
                                                     input logic [ERR_W-1:0] b);
    logic [TOTAL_ERR_W:0] sum;
    sum = {1'b0, a} + (TOTAL_ERR_W+1)'(b);
    return sum[TOTAL_ERR_W] ? '1 : sum[TOTAL_ERR_W-1:0];
  endfunction

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       sel, sel_nxt;
  logic [7:0]             iter_nxt;
  logic [NUM_GEN-1:0]     fail_nxt;
  logic [TOTAL_ERR_W-1:0] err_nxt;
  logic                   timeout_nxt, aborted_nxt;
  logic [2:0]             rst_cnt;
  logic                   start_q, start_rise, run_tc, stop;
  logic [ERR_W-1:0]       err_slice;

  assign start_rise = start && !start_q;
  assign stop       = abort || !init_calib_complete;
  assign err_slice  = gen_err_cnt[int'(sel)*ERR_W +: ERR_W];

  seq_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_run_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != RUN),
    .enable (state == RUN),
    .tc     (run_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      iter_cnt  <= '0;
      fail_mask <= '0;
      total_err <= '0;
      timeout   <= 1'b0;
      aborted   <= 1'b0;
      rst_cnt   <= '0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      iter_cnt  <= iter_nxt;
      fail_mask <= fail_nxt;
      total_err <= err_nxt;
      timeout   <= timeout_nxt;
      aborted   <= aborted_nxt;
      rst_cnt   <= (state == RESET_GEN) ? rst_cnt + 1'b1 : 3'd0;
      start_q   <= start;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    iter_nxt    = iter_cnt;
    fail_nxt    = fail_mask;
    err_nxt     = total_err;
    timeout_nxt = timeout;
    aborted_nxt = aborted;
    gen_rst_n   = '0;
    gen_start   = '0;

    case (state)
      IDLE, FINISH: begin
        if (start_rise) begin
          sel_nxt     = '0;
          iter_nxt    = '0;
          fail_nxt    = '0;
          err_nxt     = '0;
          timeout_nxt = 1'b0;
          aborted_nxt = 1'b0;
          state_nxt   = WAIT_CAL;
        end
      end
      WAIT_CAL: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = FINISH;
        end else if (init_calib_complete) begin
          state_nxt = RESET_GEN;
        end
      end
      RESET_GEN: begin
        if (stop) begin
          aborted_nxt = 1'b1;
          state_nxt   = FINISH;
        end else if (rst_cnt == RST_LAST) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        gen_rst_n[sel] = 1'b1;
        gen_start[sel] = 1'b1;
        // abort beats done, done beats timeout
        if (stop) begin
          aborted_nxt = 1'b1;
          state_nxt   = FINISH;
        end else if (gen_done[sel]) begin
          state_nxt = CHECK;
        end else if (run_tc) begin
          timeout_nxt   = 1'b1;
          fail_nxt[sel] = 1'b1;
          state_nxt     = FINISH;
        end
      end
      CHECK: begin
        gen_rst_n[sel] = 1'b1;
        gen_start[sel] = 1'b1;
        if (stop) begin
          aborted_nxt = 1'b1;
          state_nxt   = FINISH;
        end else begin
          if (err_slice != '0) fail_nxt[sel] = 1'b1;
          err_nxt   = sat_add(total_err, err_slice);
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        gen_rst_n[sel] = 1'b1;
        if (stop) begin
          aborted_nxt = 1'b1;
          state_nxt   = FINISH;
        end else if (sel != SEL_W'(NUM_GEN - 1)) begin
          sel_nxt   = sel + 1'b1;
          state_nxt = RESET_GEN;
        end else if (iter_cnt < 8'(NUM_ITER - 1)) begin
          sel_nxt   = '0;
          iter_nxt  = iter_cnt + 8'd1;
          state_nxt = RESET_GEN;
        end else begin
          state_nxt = FINISH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != FINISH);
  assign done = (state == FINISH);
  assign pass = done && (fail_mask == '0) && !timeout && !aborted;
endmodule
